// File: rtl/mips_ctrl_pkg.sv
// Shared encodings for the multicycle MIPS controller: opcodes, FSM state codes,
// ALU operation classes (also consumed by ALU control) and the control-vector layout.
package mips_ctrl_pkg;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BNZ   = 6'b000101;
    localparam logic [5:0] OP_ADDI  = 6'b001000;

    // {ALUop2,ALUop1}
    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_BNZ   = 2'b01;
    localparam logic [1:0] ALUOP_RTYPE = 2'b10;
    localparam logic [1:0] ALUOP_ITYPE = 2'b11;

    typedef enum logic [3:0] {
        ST_FETCH      = 4'd0,
        ST_DECODE     = 4'd1,
        ST_MEMADDR    = 4'd2,
        ST_MEMREAD    = 4'd3,
        ST_MEMWB      = 4'd4,
        ST_MEMWRITE   = 4'd5,
        ST_EXECUTE    = 4'd6,
        ST_RTYPE_WB   = 4'd7,
        ST_BRANCH     = 4'd8,
        ST_ITYPE_EXEC = 4'd9,
        ST_ITYPE_WB   = 4'd10,
        ST_TRAP       = 4'd11
    } state_t;

    typedef struct packed {
        logic       PCWrite;
        logic       PCWriteCond;
        logic       IorD;
        logic       MemRead;
        logic       MemWrite;
        logic       MemtoReg;
        logic       IRWrite;
        logic       RegWrite;
        logic       RegDst;
        logic       ALUSrcA;
        logic [1:0] ALUSrcB;
        logic [1:0] ALUop;
        logic [1:0] PCSource;
    } ctrl_t;

endpackage

// File: rtl/multicycle_control_outdec.sv
// Moore output decode for the multicycle controller; only the FETCH strobes
// IRWrite/PCWrite look at memReady so a stalled fetch never advances the PC.
module multicycle_control_outdec
    import mips_ctrl_pkg::*;
(
    input  state_t i_state,
    input  logic   i_memReady,
    output ctrl_t  o_ctrl
);

    always_comb begin
        o_ctrl = '0;
        case (i_state)
            ST_FETCH: begin
                o_ctrl.MemRead  = 1'b1;
                o_ctrl.IRWrite  = i_memReady;
                o_ctrl.PCWrite  = i_memReady;
                o_ctrl.ALUSrcB  = 2'b01;
                o_ctrl.ALUop    = ALUOP_ADD;
                o_ctrl.PCSource = 2'b00;
            end
            ST_DECODE: begin
                o_ctrl.ALUSrcB = 2'b11;
                o_ctrl.ALUop   = ALUOP_ADD;
            end
            ST_MEMADDR: begin
                o_ctrl.ALUSrcA = 1'b1;
                o_ctrl.ALUSrcB = 2'b10;
                o_ctrl.ALUop   = ALUOP_ADD;
            end
            ST_MEMREAD: begin
                o_ctrl.MemRead = 1'b1;
                o_ctrl.IorD    = 1'b1;
            end
            ST_MEMWB: begin
                o_ctrl.RegWrite = 1'b1;
                o_ctrl.MemtoReg = 1'b1;
            end
            ST_MEMWRITE: begin
                o_ctrl.MemWrite = 1'b1;
                o_ctrl.IorD     = 1'b1;
            end
            ST_EXECUTE: begin
                o_ctrl.ALUSrcA = 1'b1;
                o_ctrl.ALUSrcB = 2'b00;
                o_ctrl.ALUop   = ALUOP_RTYPE;
            end
            ST_RTYPE_WB: begin
                o_ctrl.RegWrite = 1'b1;
                o_ctrl.RegDst   = 1'b1;
            end
            ST_BRANCH: begin
                o_ctrl.ALUSrcA     = 1'b1;
                o_ctrl.ALUop       = ALUOP_BNZ;
                o_ctrl.PCWriteCond = 1'b1;
                o_ctrl.PCSource    = 2'b01;
            end
            ST_ITYPE_EXEC: begin
                o_ctrl.ALUSrcA = 1'b1;
                o_ctrl.ALUSrcB = 2'b10;
                o_ctrl.ALUop   = ALUOP_ITYPE;
            end
            ST_ITYPE_WB: o_ctrl.RegWrite = 1'b1;
            default: ;  // TRAP and unused codes keep every strobe low
        endcase
    end

endmodule

// File: rtl/multicycle_control.sv
// Multicycle MIPS control FSM: next-state logic, opcode latch and state register.
// Define ILLEGAL_TRAP_EN to send unknown opcodes to a sticky TRAP state.
module multicycle_control
    import mips_ctrl_pkg::*;
#(
    parameter int OPCODE_W = 6
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [OPCODE_W-1:0] inpOpcode,
    input  logic                memReady,
    output logic                ALUop1,
    output logic                ALUop2,
    output logic                PCWrite,
    output logic                PCWriteCond,
    output logic                IorD,
    output logic                MemRead,
    output logic                MemWrite,
    output logic                MemtoReg,
    output logic                IRWrite,
    output logic                RegWrite,
    output logic                RegDst,
    output logic                ALUSrcA,
    output logic [1:0]          ALUSrcB,
    output logic [1:0]          PCSource,
    output logic [3:0]          state_o,
    output logic                illegalOp
);

    localparam logic [OPCODE_W-1:0] L_RTYPE = OPCODE_W'(OP_RTYPE);
    localparam logic [OPCODE_W-1:0] L_LW    = OPCODE_W'(OP_LW);
    localparam logic [OPCODE_W-1:0] L_SW    = OPCODE_W'(OP_SW);
    localparam logic [OPCODE_W-1:0] L_BNZ   = OPCODE_W'(OP_BNZ);
    localparam logic [OPCODE_W-1:0] L_ADDI  = OPCODE_W'(OP_ADDI);

    state_t                r_state;
    state_t                w_next;
    logic [OPCODE_W-1:0]   r_opcode;
    ctrl_t                 w_ctrl;

    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_FETCH:      if (memReady) w_next = ST_DECODE;
            ST_DECODE: begin
                if (inpOpcode == L_RTYPE)                          w_next = ST_EXECUTE;
                else if (inpOpcode == L_LW || inpOpcode == L_SW)   w_next = ST_MEMADDR;
                else if (inpOpcode == L_BNZ)                       w_next = ST_BRANCH;
                else if (inpOpcode == L_ADDI)                      w_next = ST_ITYPE_EXEC;
`ifdef ILLEGAL_TRAP_EN
                else                                               w_next = ST_TRAP;
`else
                else                                               w_next = ST_FETCH;
`endif
            end
            // Live inpOpcode may already belong to the next fetch; use the latched copy.
            ST_MEMADDR:    w_next = (r_opcode == L_SW) ? ST_MEMWRITE : ST_MEMREAD;
            ST_MEMREAD:    if (memReady) w_next = ST_MEMWB;
            ST_MEMWRITE:   if (memReady) w_next = ST_FETCH;
            ST_EXECUTE:    w_next = ST_RTYPE_WB;
            ST_ITYPE_EXEC: w_next = ST_ITYPE_WB;
            ST_RTYPE_WB,
            ST_ITYPE_WB,
            ST_MEMWB,
            ST_BRANCH:     w_next = ST_FETCH;
`ifdef ILLEGAL_TRAP_EN
            ST_TRAP:       w_next = ST_TRAP;
`endif
            default:       w_next = ST_FETCH;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state  <= ST_FETCH;
            r_opcode <= '0;
        end else begin
            r_state <= w_next;
            if (r_state == ST_DECODE) r_opcode <= inpOpcode;
        end
    end

`ifdef ILLEGAL_TRAP_EN
    logic r_illegal;

    always_ff @(posedge clk) begin
        if (reset)                  r_illegal <= 1'b0;
        else if (w_next == ST_TRAP) r_illegal <= 1'b1;
    end

    assign illegalOp = r_illegal;
`else
    assign illegalOp = 1'b0;
`endif

    multicycle_control_outdec u_outdec (
        .i_state    (r_state),
        .i_memReady (memReady),
        .o_ctrl     (w_ctrl)
    );

    assign PCWrite     = w_ctrl.PCWrite;
    assign PCWriteCond = w_ctrl.PCWriteCond;
    assign IorD        = w_ctrl.IorD;
    assign MemRead     = w_ctrl.MemRead;
    assign MemWrite    = w_ctrl.MemWrite;
    assign MemtoReg    = w_ctrl.MemtoReg;
    assign IRWrite     = w_ctrl.IRWrite;
    assign RegWrite    = w_ctrl.RegWrite;
    assign RegDst      = w_ctrl.RegDst;
    assign ALUSrcA     = w_ctrl.ALUSrcA;
    assign ALUSrcB     = w_ctrl.ALUSrcB;
    assign PCSource    = w_ctrl.PCSource;
    assign ALUop2      = w_ctrl.ALUop[1];
    assign ALUop1      = w_ctrl.ALUop[0];
    assign state_o     = r_state;

endmodule

// File: tb/tb_multicycle_control.sv
// Directed bench for multicycle_control: per-instruction state walks, stalls,
// opcode latching, illegal opcode handling and reset mid-stall.
module tb_multicycle_control;

    logic       clk = 1'b0;
    logic       reset;
    logic [5:0] inpOpcode;
    logic       memReady;
    logic       ALUop1, ALUop2, PCWrite, PCWriteCond, IorD, MemRead, MemWrite;
    logic       MemtoReg, IRWrite, RegWrite, RegDst, ALUSrcA;
    logic [1:0] ALUSrcB, PCSource;
    logic [3:0] state_o;
    logic       illegalOp;

    int n_checks = 0;
    int n_fail   = 0;

    multicycle_control #(.OPCODE_W(6)) dut (
        .clk(clk), .reset(reset), .inpOpcode(inpOpcode), .memReady(memReady),
        .ALUop1(ALUop1), .ALUop2(ALUop2), .PCWrite(PCWrite), .PCWriteCond(PCWriteCond),
        .IorD(IorD), .MemRead(MemRead), .MemWrite(MemWrite), .MemtoReg(MemtoReg),
        .IRWrite(IRWrite), .RegWrite(RegWrite), .RegDst(RegDst), .ALUSrcA(ALUSrcA),
        .ALUSrcB(ALUSrcB), .PCSource(PCSource), .state_o(state_o), .illegalOp(illegalOp)
    );

    always #5 clk = ~clk;

    // {PCWrite,PCWriteCond,IorD,MemRead,MemWrite,MemtoReg,IRWrite,RegWrite,RegDst,ALUSrcA,ALUSrcB,ALUop2,ALUop1,PCSource}
    logic [15:0] ctrl;
    assign ctrl = {PCWrite, PCWriteCond, IorD, MemRead, MemWrite, MemtoReg, IRWrite,
                   RegWrite, RegDst, ALUSrcA, ALUSrcB, ALUop2, ALUop1, PCSource};

    // Expected control vectors, hand-encoded from the per-state output table.
    function automatic logic [15:0] exp_ctrl(input int st, input logic mr);
        case (st)
            0:       return mr ? 16'h9210 : 16'h1010;
            1:       return 16'h0030;
            2:       return 16'h0060;
            3:       return 16'h3000;
            4:       return 16'h0500;
            5:       return 16'h2800;
            6:       return 16'h0048;
            7:       return 16'h0180;
            8:       return 16'h4045;
            9:       return 16'h006C;
            10:      return 16'h0100;
            default: return 16'h0000;
        endcase
    endfunction

    // Read and write strobes must never overlap.
    always @(negedge clk) begin
        if (reset === 1'b0) begin
            n_checks++;
            if ((MemRead & MemWrite) !== 1'b0) begin
                n_fail++;
                $display("FAIL rd_wr_exclusive: MemRead=%b MemWrite=%b state=%0d", MemRead, MemWrite, state_o);
            end
        end
    end

    task automatic test_reset();
        reset = 1'b1; memReady = 1'b0; inpOpcode = 6'b000000;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        #1;
        n_checks++;
        if (state_o !== 4'd0) begin n_fail++; $display("FAIL reset_state: got %0d want 0", state_o); end
        n_checks++;
        if (ctrl !== 16'h1010) begin n_fail++; $display("FAIL reset_ctrl_stall: got %h want 1010", ctrl); end
        n_checks++;
        if (illegalOp !== 1'b0) begin n_fail++; $display("FAIL reset_illegal: got %b want 0", illegalOp); end
        memReady = 1'b1; #1;
        n_checks++;
        if (ctrl !== 16'h9210) begin n_fail++; $display("FAIL reset_ctrl_ready: got %h want 9210", ctrl); end
    endtask

    // LW; inpOpcode is only LW during DECODE, SW elsewhere, so MEMADDR must use the latch.
    task automatic test_lw();
        int st[6] = '{0, 1, 2, 3, 4, 0};
        int rw_cnt = 0;
        for (int i = 0; i < 6; i++) begin
            if (i > 0) begin @(posedge clk); #1; end
            memReady = 1'b1;
            inpOpcode = (i == 1) ? 6'b100011 : 6'b101011;
            #1;
            n_checks++;
            if (state_o !== 4'(st[i])) begin n_fail++; $display("FAIL lw_state[%0d]: got %0d want %0d", i, state_o, st[i]); end
            n_checks++;
            if (ctrl !== exp_ctrl(st[i], 1'b1)) begin n_fail++; $display("FAIL lw_ctrl[%0d]: got %h want %h", i, ctrl, exp_ctrl(st[i], 1'b1)); end
            if (i < 5 && RegWrite && MemtoReg) rw_cnt++;
        end
        n_checks++;
        if (rw_cnt !== 1) begin n_fail++; $display("FAIL lw_regwrite_cycles: got %0d want 1", rw_cnt); end
    endtask

    task automatic test_rtype();
        int st[5] = '{0, 1, 6, 7, 0};
        for (int i = 0; i < 5; i++) begin
            if (i > 0) begin @(posedge clk); #1; end
            memReady = 1'b1; inpOpcode = 6'b000000; #1;
            n_checks++;
            if (state_o !== 4'(st[i])) begin n_fail++; $display("FAIL rtype_state[%0d]: got %0d want %0d", i, state_o, st[i]); end
            n_checks++;
            if (ctrl !== exp_ctrl(st[i], 1'b1)) begin n_fail++; $display("FAIL rtype_ctrl[%0d]: got %h want %h", i, ctrl, exp_ctrl(st[i], 1'b1)); end
        end
    endtask

    task automatic test_sw_stall();
        int   st[8] = '{0, 1, 2, 5, 5, 5, 5, 0};
        logic mr[8] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
        int mw_cnt = 0, pc_cnt = 0;
        for (int i = 0; i < 8; i++) begin
            if (i > 0) begin @(posedge clk); #1; end
            memReady = mr[i]; inpOpcode = (i == 1) ? 6'b101011 : 6'b100011; #1;
            n_checks++;
            if (state_o !== 4'(st[i])) begin n_fail++; $display("FAIL sw_state[%0d]: got %0d want %0d", i, state_o, st[i]); end
            n_checks++;
            if (ctrl !== exp_ctrl(st[i], mr[i])) begin n_fail++; $display("FAIL sw_ctrl[%0d]: got %h want %h", i, ctrl, exp_ctrl(st[i], mr[i])); end
            if (i < 7) begin mw_cnt += int'(MemWrite); pc_cnt += int'(PCWrite); end
        end
        n_checks++;
        if (mw_cnt !== 4) begin n_fail++; $display("FAIL sw_memwrite_cycles: got %0d want 4", mw_cnt); end
        n_checks++;
        if (pc_cnt !== 1) begin n_fail++; $display("FAIL sw_pcwrite_pulses: got %0d want 1", pc_cnt); end
    endtask

    task automatic test_bnz();
        int st[4] = '{0, 1, 8, 0};
        for (int i = 0; i < 4; i++) begin
            if (i > 0) begin @(posedge clk); #1; end
            memReady = 1'b1; inpOpcode = 6'b000101; #1;
            n_checks++;
            if (state_o !== 4'(st[i])) begin n_fail++; $display("FAIL bnz_state[%0d]: got %0d want %0d", i, state_o, st[i]); end
            n_checks++;
            if (ctrl !== exp_ctrl(st[i], 1'b1)) begin n_fail++; $display("FAIL bnz_ctrl[%0d]: got %h want %h", i, ctrl, exp_ctrl(st[i], 1'b1)); end
        end
    endtask

    // ADDI preceded by a two-cycle fetch stall: PCWrite/IRWrite stay low until memReady.
    task automatic test_fetch_stall_addi();
        int   st[7] = '{0, 0, 0, 1, 9, 10, 0};
        logic mr[7] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
        for (int i = 0; i < 7; i++) begin
            if (i > 0) begin @(posedge clk); #1; end
            memReady = mr[i]; inpOpcode = 6'b001000; #1;
            n_checks++;
            if (state_o !== 4'(st[i])) begin n_fail++; $display("FAIL addi_state[%0d]: got %0d want %0d", i, state_o, st[i]); end
            n_checks++;
            if (ctrl !== exp_ctrl(st[i], mr[i])) begin n_fail++; $display("FAIL addi_ctrl[%0d]: got %h want %h", i, ctrl, exp_ctrl(st[i], mr[i])); end
        end
    endtask

    task automatic test_illegal();
        memReady = 1'b1; inpOpcode = 6'b111111;
        @(posedge clk); #1;  // FETCH -> DECODE
        n_checks++;
        if (state_o !== 4'd1) begin n_fail++; $display("FAIL illegal_decode: got %0d want 1", state_o); end
`ifdef ILLEGAL_TRAP_EN
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            n_checks++;
            if (state_o !== 4'd11 || illegalOp !== 1'b1 || ctrl !== 16'h0000) begin
                n_fail++;
                $display("FAIL illegal_trap[%0d]: state=%0d illegalOp=%b ctrl=%h want 11/1/0000", i, state_o, illegalOp, ctrl);
            end
        end
        reset = 1'b1; @(posedge clk); #1 reset = 1'b0; #1;
        n_checks++;
        if (state_o !== 4'd0 || illegalOp !== 1'b0) begin
            n_fail++; $display("FAIL trap_reset: state=%0d illegalOp=%b want 0/0", state_o, illegalOp);
        end
`else
        @(posedge clk); #1;
        n_checks++;
        if (state_o !== 4'd0 || illegalOp !== 1'b0) begin
            n_fail++; $display("FAIL illegal_nop: state=%0d illegalOp=%b want 0/0", state_o, illegalOp);
        end
`endif
    endtask

    task automatic test_reset_mid_stall();
        memReady = 1'b1; inpOpcode = 6'b100011;
        repeat (3) @(posedge clk);  // FETCH -> DECODE -> MEMADDR -> MEMREAD
        #1 memReady = 1'b0;
        @(posedge clk); #1;
        n_checks++;
        if (state_o !== 4'd3) begin n_fail++; $display("FAIL stall_memread: got %0d want 3", state_o); end
        reset = 1'b1;
        @(posedge clk); #1;
        n_checks++;
        if (state_o !== 4'd0) begin n_fail++; $display("FAIL midstall_reset_state: got %0d want 0", state_o); end
        n_checks++;
        if (MemRead !== 1'b1 || IorD !== 1'b0 || RegWrite !== 1'b0) begin
            n_fail++; $display("FAIL midstall_reset_ctrl: MemRead=%b IorD=%b RegWrite=%b want 1/0/0", MemRead, IorD, RegWrite);
        end
        reset = 1'b0;
    endtask

    initial begin
        test_reset();
        test_lw();
        test_rtype();
        test_sw_stall();
        test_bnz();
        test_fetch_stall_addi();
        test_illegal();
        test_reset_mid_stall();
        @(posedge clk); #1;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
